// File: rtl/ras_pkg.sv
// Shared fetch-predictor types: RAS geometry, PC38 targets and checkpoint widths.
package ras_pkg;

  localparam int RAS_ENTRIES     = 16;
  localparam int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES);
  localparam int PC_WIDTH        = 38;

  typedef logic [PC_WIDTH-1:0]        PC38_t;
  typedef logic [LOG_RAS_ENTRIES-1:0] RAS_idx_t;
  typedef logic [LOG_RAS_ENTRIES:0]   RAS_count_t;

  localparam PC38_t      INIT_PC38     = '0;
  localparam RAS_count_t RAS_COUNT_MAX = RAS_count_t'(RAS_ENTRIES);

endpackage

// File: rtl/ras.sv
// Circular return address stack; ret_PC38 is combinational from the top entry.
// Restore (update) beats push/pop; no backpressure, a full stack silently overwrites its oldest entry.
module ras
  import ras_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       link_valid,
  input  PC38_t      link_PC38,
  input  logic       ret_valid,
  output PC38_t      ret_PC38,
  output logic       ret_empty,
  output RAS_idx_t   ras_idx,
  output RAS_count_t ras_count,
  input  logic       update_valid,
  input  RAS_idx_t   update_ras_idx,
  input  RAS_count_t update_ras_count
);

  PC38_t      stack [RAS_ENTRIES];
  RAS_idx_t   ptr;
  RAS_count_t count;
  RAS_idx_t   ptr_inc;
  RAS_idx_t   ptr_dec;

  assign ptr_inc = ptr + 1'b1;
  assign ptr_dec = ptr - 1'b1;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) stack[i] <= INIT_PC38;
    end else if (update_valid) begin
      ptr   <= update_ras_idx;
      count <= (update_ras_count > RAS_COUNT_MAX) ? RAS_COUNT_MAX : update_ras_count;
    end else if (link_valid && ret_valid) begin
      // Coroutine return: replace the top in place, depth is unchanged.
      stack[ptr] <= link_PC38;
      if (count == '0) count <= RAS_count_t'(1);
    end else if (link_valid) begin
      ptr            <= ptr_inc;
      stack[ptr_inc] <= link_PC38;
      if (count != RAS_COUNT_MAX) count <= count + 1'b1;
    end else if (ret_valid) begin
      // Underflow still moves the pointer so a later restore sees consistent history.
      ptr <= ptr_dec;
      if (count != '0) count <= count - 1'b1;
    end
  end

  assign ret_PC38  = stack[ptr];
  assign ret_empty = (count == '0);
  assign ras_idx   = ptr;
  assign ras_count = count;

endmodule

// File: tb/tb_ras.sv
// Directed and random checks of the return address stack against a modulo-arithmetic reference model.
module tb_ras;
  import ras_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       link_valid;
  PC38_t      link_PC38;
  logic       ret_valid;
  PC38_t      ret_PC38;
  logic       ret_empty;
  RAS_idx_t   ras_idx;
  RAS_count_t ras_count;
  logic       update_valid;
  RAS_idx_t   update_ras_idx;
  RAS_count_t update_ras_count;

  ras dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .link_valid       (link_valid),
    .link_PC38        (link_PC38),
    .ret_valid        (ret_valid),
    .ret_PC38         (ret_PC38),
    .ret_empty        (ret_empty),
    .ras_idx          (ras_idx),
    .ras_count        (ras_count),
    .update_valid     (update_valid),
    .update_ras_idx   (update_ras_idx),
    .update_ras_count (update_ras_count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integers, wrap by modulo.
  logic [63:0] m_stack [16];
  int          m_ptr;
  int          m_cnt;
  logic [63:0] seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_stack[i] = 64'd0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  // One clock: drive, check the combinational top, clock, advance the model, check registered state.
  task automatic step(input logic l, input logic [37:0] lpc, input logic r,
                      input logic u = 1'b0, input logic [3:0] ui = 4'd0,
                      input logic [4:0] uc = 5'd0, input logic rst_n = 1'b1);
    nRST = rst_n; link_valid = l; link_PC38 = lpc; ret_valid = r;
    update_valid = u; update_ras_idx = ui; update_ras_count = uc;
    #1;
    seen = 64'(ret_PC38);
    chk("top_same_cycle", seen, m_stack[m_ptr]);
    @(posedge CLK);
    if (!rst_n) model_reset();
    else if (u) begin
      m_ptr = int'(ui);
      m_cnt = (int'(uc) > 16) ? 16 : int'(uc);
    end else if (l && r) begin
      m_stack[m_ptr] = 64'(lpc);
      if (m_cnt == 0) m_cnt = 1;
    end else if (l) begin
      m_ptr = (m_ptr + 1) % 16;
      m_stack[m_ptr] = 64'(lpc);
      if (m_cnt < 16) m_cnt++;
    end else if (r) begin
      m_ptr = (m_ptr + 15) % 16;
      if (m_cnt > 0) m_cnt--;
    end
    #1;
    chk("top_after", 64'(ret_PC38), m_stack[m_ptr]);
    chk("idx_after", 64'(ras_idx), 64'(m_ptr));
    chk("count_after", 64'(ras_count), 64'(m_cnt));
    chk("empty_after", 64'(ret_empty), 64'(m_cnt == 0));
  endtask

  task automatic push(input logic [37:0] v);
    step(1'b1, v, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 38'h0, 1'b1);
  endtask

  initial begin
    model_reset();
    nRST = 1'b0; link_valid = 1'b0; link_PC38 = '0; ret_valid = 1'b0;
    update_valid = 1'b0; update_ras_idx = '0; update_ras_count = '0;
    @(posedge CLK); #1;

    // Reset state and first push.
    step(1'b0, 38'h0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
    chk("rst_top", 64'(ret_PC38), 64'h0);
    chk("rst_empty", 64'(ret_empty), 64'd1);
    chk("rst_idx", 64'(ras_idx), 64'd0);
    chk("rst_count", 64'(ras_count), 64'd0);
    push(38'h100);
    chk("push1_top", 64'(ret_PC38), 64'h100);
    chk("push1_idx", 64'(ras_idx), 64'd1);
    chk("push1_count", 64'(ras_count), 64'd1);
    chk("push1_empty", 64'(ret_empty), 64'd0);
    pop();
    chk("pop1_seen", seen, 64'h100);

    // LIFO order.
    push(38'h10); push(38'h20); push(38'h30);
    pop(); chk("lifo_seen0", seen, 64'h30);
    pop(); chk("lifo_seen1", seen, 64'h20);
    pop(); chk("lifo_seen2", seen, 64'h10);
    chk("lifo_count", 64'(ras_count), 64'd0);
    chk("lifo_empty", 64'(ret_empty), 64'd1);
    chk("lifo_idx", 64'(ras_idx), 64'd0);

    // Overflow wrap: 17 pushes overwrite the oldest.
    for (int i = 1; i <= 17; i++) push(38'(i));
    chk("wrap_count", 64'(ras_count), 64'd16);
    chk("wrap_idx", 64'(ras_idx), 64'd1);
    chk("wrap_top", 64'(ret_PC38), 64'h11);
    for (int k = 0; k < 16; k++) begin
      pop();
      chk("wrap_pop_seen", seen, 64'(17 - k));
    end
    chk("wrap_final_count", 64'(ras_count), 64'd0);

    // Simultaneous push and pop.
    step(1'b0, 38'h0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
    push(38'h1); push(38'h2); push(38'hAA);
    step(1'b1, 38'hBB, 1'b1);
    chk("co_seen", seen, 64'hAA);
    chk("co_top", 64'(ret_PC38), 64'hBB);
    chk("co_idx", 64'(ras_idx), 64'd3);
    chk("co_count", 64'(ras_count), 64'd3);

    // Restore beats push.
    push(38'h44); push(38'h55);
    chk("pre_upd_idx", 64'(ras_idx), 64'd5);
    step(1'b1, 38'hCC, 1'b0, 1'b1, 4'd2, 5'd2);
    chk("upd_idx", 64'(ras_idx), 64'd2);
    chk("upd_count", 64'(ras_count), 64'd2);
    chk("upd_top", 64'(ret_PC38), 64'h2);
    step(1'b0, 38'h0, 1'b1, 1'b1, 4'd7, 5'd31);
    chk("upd_sat_count", 64'(ras_count), 64'd16);
    chk("upd_sat_idx", 64'(ras_idx), 64'd7);

    // Underflow and reset-overrides-push.
    step(1'b0, 38'h0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
    pop();
    chk("under_idx", 64'(ras_idx), 64'd15);
    chk("under_count", 64'(ras_count), 64'd0);
    chk("under_empty", 64'(ret_empty), 64'd1);
    push(38'h77); push(38'h88);
    step(1'b1, 38'h99, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
    chk("rst2_idx", 64'(ras_idx), 64'd0);
    chk("rst2_count", 64'(ras_count), 64'd0);
    chk("rst2_top", 64'(ret_PC38), 64'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      int op;
      op = int'($urandom_range(0, 19));
      if ($urandom_range(0, 149) == 0)
        step(1'b1, 38'($urandom), 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
      else if (op < 8)
        push({6'($urandom), 32'($urandom)});
      else if (op < 15)
        pop();
      else if (op < 18)
        step(1'b1, {6'($urandom), 32'($urandom)}, 1'b1);
      else
        step(1'($urandom), 38'($urandom), 1'($urandom), 1'b1,
             4'($urandom), 5'($urandom_range(0, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ras.md
Name: ras

Overview:
- Return address stack for the fetch predictor complex: 1-wide circular stack of PC38 return targets.
- Sits beside the BTB/GBPT in the fetch stage.
- Pushed on BTB link-type actions (JUMP_L, RET_L, INDIRECT_L); popped on RET/RET_L.
- Exposes its top-of-stack pointer and count so the frontend can checkpoint them and restore on mispredict.

Parameters:
- RAS_ENTRIES, 16, stack depth; power of 2.
- LOG_RAS_ENTRIES, 4, pointer width, equal to clog2(RAS_ENTRIES).
- PC_WIDTH, 38, stored target width (PC38_t).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- link_valid  in  1  push request this cycle.
- link_PC38  in  38  return address to push.
- ret_valid  in  1  pop request this cycle.
- ret_PC38  out  38  current top-of-stack entry, combinational from stack[ptr].
- ret_empty  out  1  count == 0; predicted return target is not trustworthy.
- ras_idx  out  4  current top pointer, for checkpointing.
- ras_count  out  5  current valid count, 0..RAS_ENTRIES, for checkpointing.
- update_valid  in  1  restore request from mispredict or checkpoint.
- update_ras_idx  in  4  pointer to restore.
- update_ras_count  in  5  count to restore; values above RAS_ENTRIES saturate to RAS_ENTRIES.

Behaviour:
- State:
  - stack[RAS_ENTRIES] of PC38.
  - ptr (LOG_RAS_ENTRIES bits).
  - count (LOG_RAS_ENTRIES+1 bits).
- Reset (nRST low at clock edge, synchronous):
  - ptr = 0, count = 0.
  - Every stack entry = INIT_PC38 (38'h0).
  - Outputs after reset: ret_PC38 = 0, ret_empty = 1, ras_idx = 0, ras_count = 0.
  - Reset overrides all other inputs in the same cycle.
- Read path: ret_PC38 = stack[ptr], zero-cycle latency.
  - The value seen in a pop cycle is the value being popped.
  - ret_empty and ras_idx/ras_count reflect registered state, not this cycle's requests.
- Per-cycle priority: reset > update > push/pop.
- update_valid = 1:
  - ptr <= update_ras_idx; count <= min(update_ras_count, RAS_ENTRIES).
  - Stack contents are untouched.
  - link_valid and ret_valid are ignored that cycle.
- Push only (link_valid = 1, ret_valid = 0):
  - ptr <= ptr+1 (mod RAS_ENTRIES); stack[ptr+1] <= link_PC38.
  - count <= count+1, saturating at RAS_ENTRIES.
  - At full, wrap-around silently overwrites the oldest entry.
- Pop only (link_valid = 0, ret_valid = 1):
  - ptr <= ptr-1 (mod RAS_ENTRIES); count <= count-1, saturating at 0.
  - Pop when empty still decrements ptr (wraps 0 -> 15); count stays 0 and ret_empty stays 1.
- Push and pop together (coroutine / RET_L):
  - stack[ptr] <= link_PC38; ptr unchanged.
  - count unchanged, except count 0 -> 1.
  - ret_PC38 in that cycle is the old stack[ptr].
- No request: all state holds.
- Arithmetic: all pointer math is modulo RAS_ENTRIES via natural LOG_RAS_ENTRIES-bit wrap; no overflow flag.
- Reset mid-stream: any in-flight push/pop in the reset cycle is dropped.

Decomposition:
- Shared core types package already carries RAS_ENTRIES, LOG_RAS_ENTRIES, RAS_idx_t and PC38_t.
- Add RAS_count_t (logic [LOG_RAS_ENTRIES:0]) there for the checkpoint array's use.
- Single module; no sub-module. The stack is a flop array, small enough that no RAM macro is needed.

Test Plan:
- Reset -> ret_PC38 = 0, ret_empty = 1, ras_idx = 0, ras_count = 0. Then push 38'h100 -> next cycle ret_PC38 = 38'h100, ras_idx = 1, ras_count = 1, ret_empty = 0.
- Push 38'h10, 38'h20, 38'h30, then pop three times -> ret_PC38 reads 38'h30, 38'h20, 38'h10 in the pop cycles; finally ras_count = 0, ret_empty = 1, ras_idx = 0.
- Push 17 values 38'h1..38'h11 -> ras_count = 16, ras_idx = 1, stack[1] = 38'h11 (oldest entry overwritten). Pop 16 times -> 38'h11 down to 38'h2 returned, ras_count = 0.
- From ras_idx = 3, ras_count = 3 with top 38'hAA, assert push 38'hBB and pop together -> same-cycle ret_PC38 = 38'hAA; next cycle ret_PC38 = 38'hBB, ras_idx = 3, ras_count = 3.
- After pushes reach ras_idx = 5, ras_count = 5, assert update_valid with idx 2, count 2 together with link_valid -> next cycle ras_idx = 2, ras_count = 2, push ignored, stack[2] unchanged.
- Pop while empty at ras_idx = 0 -> ras_idx = 15, ras_count = 0, ret_empty = 1. Assert nRST = 0 in the same cycle as a push -> all state returns to reset values.
